cpu_run_ctrl: RTL

Parametrised run controller sitting between the board/bench clock-reset source and the multicycle CPU (FinalCPU). It stretches CPU reset for a programmable number of cycles and gates CPU progress through a clock enable, in either free-run or single-step mode. It counts executed CPU cycles and ends a run on CPU halt or on a watchdog timeout. It replaces fixed-delay reset release with a reusable, observable sequencer.

---
 rtl/cpu_run_ctrl.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/cpu_run_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_run_ctrl
//
// Run controller placed between the clock/reset source and the multicycle
// CPU. It holds the CPU in reset for RESET_CYCLES cycles after a start
// request. It then lets the CPU advance through a clock enable, either on
// every cycle (free-run) or one cycle per step request (single-step). It
// counts enabled CPU cycles and ends the run when the CPU halts or when a
// watchdog expires.
//
// Parameters
//   RESET_CYCLES  cycles cpu_reset is held after start (>= 1)
//   CNT_W         width of cycle_count
//   TIMEOUT       watchdog limit in enabled cycles; 0 disables it
//
// Ports
//   clk          system clock; all logic is on the rising edge
//   reset        asynchronous, active-high controller reset
//   start        pulse; begins a run from IDLE or DONE
//   step_mode    sampled with start: 1 = single-step, 0 = free-run
//   step_req     single-step request; one pulse gives one enabled cycle
//   halt         level from the CPU; the program has finished
//   abort        returns to IDLE from any state
//   cpu_reset    active-high reset to the CPU
//   cpu_en       CPU clock enable
//   busy         high while in RESET or RUN
//   done         sticky; the run ended by halt or timeout
//   timed_out    sticky; the run ended by watchdog
//   cycle_count  number of edges with cpu_en=1 since the last start
//   dbg_state    current sequencer state (IDLE=0, RESET=1, RUN=2, DONE=3)
//
// Handshake: there is no valid/ready pair here. start, step_req and abort
// are edge-sampled requests: each one acts on the first rising edge where
// it is seen high. halt is a level input. Per edge, the priority is
// reset > abort > start > halt > timeout > step/run.
// -----------------------------------------------------------------------------
module cpu_run_ctrl #(
    parameter int RESET_CYCLES = 5,
    parameter int CNT_W        = 32,
    parameter int TIMEOUT      = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step_req,
    input  logic             halt,
    input  logic             abort,
    output logic             cpu_reset,
    output logic             cpu_en,
    output logic             busy,
    output logic             done,
    output logic             timed_out,
    output logic [CNT_W-1:0] cycle_count,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RESET = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Reset counter is wide enough to hold RESET_CYCLES itself.
    localparam int RC_W = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES + 1);

    localparam logic [RC_W-1:0]  RC_LOAD  = RC_W'(RESET_CYCLES);
    localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    // Count value seen on the edge that expires the watchdog. It is only
    // used when TIMEOUT is non-zero, so the wrap at TIMEOUT=0 is harmless.
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic             TO_ON    = (TIMEOUT != 0);

    // Registered state
    state_t            state;
    logic [RC_W-1:0]   rcnt;
    logic              step_lat;

    // Next-state values
    state_t            state_n;
    logic [RC_W-1:0]   rcnt_n;
    logic              step_lat_n;
    logic              cpu_reset_n;
    logic              cpu_en_n;
    logic              busy_n;
    logic              done_n;
    logic              timed_out_n;
    logic [CNT_W-1:0]  cycle_count_n;
    logic              wdog_hit;

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            rcnt        <= '0;
            step_lat    <= 1'b0;
            cpu_reset   <= 1'b1;
            cpu_en      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timed_out   <= 1'b0;
            cycle_count <= '0;
        end else begin
            state       <= state_n;
            rcnt        <= rcnt_n;
            step_lat    <= step_lat_n;
            cpu_reset   <= cpu_reset_n;
            cpu_en      <= cpu_en_n;
            busy        <= busy_n;
            done        <= done_n;
            timed_out   <= timed_out_n;
            cycle_count <= cycle_count_n;
        end
    end

    // The watchdog fires on the edge that takes the count to TIMEOUT.
    assign wdog_hit = TO_ON && cpu_en && (cycle_count == TO_LAST);

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_n       = state;
        rcnt_n        = rcnt;
        step_lat_n    = step_lat;
        cpu_reset_n   = cpu_reset;
        cpu_en_n      = 1'b0;
        busy_n        = busy;
        done_n        = done;
        timed_out_n   = timed_out;
        cycle_count_n = cycle_count;

        // Every edge on which the CPU was enabled is counted, including the
        // final edge of a run (halt, timeout or abort). The count saturates
        // instead of wrapping.
        if (cpu_en && (cycle_count != CNT_MAX)) begin
            cycle_count_n = cycle_count + 1'b1;
        end

        if (abort) begin
            state_n     = S_IDLE;
            cpu_reset_n = 1'b1;
            cpu_en_n    = 1'b0;
            busy_n      = 1'b0;
            done_n      = 1'b0;
            timed_out_n = 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_n       = S_RESET;
                        rcnt_n        = RC_LOAD;
                        step_lat_n    = step_mode;
                        cpu_reset_n   = 1'b1;
                        busy_n        = 1'b1;
                        done_n        = 1'b0;
                        timed_out_n   = 1'b0;
                        cycle_count_n = '0;
                    end
                end

                S_RESET: begin
                    if (rcnt == RC_LAST) begin
                        // Release the CPU. In free-run mode the first RUN
                        // cycle is already enabled.
                        state_n     = S_RUN;
                        cpu_reset_n = 1'b0;
                        cpu_en_n    = ~step_lat;
                    end else begin
                        rcnt_n = rcnt - 1'b1;
                    end
                end

                S_RUN: begin
                    if (halt) begin
                        // Halt wins over a coincident watchdog expiry.
                        state_n = S_DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else if (wdog_hit) begin
                        state_n     = S_DONE;
                        busy_n      = 1'b0;
                        done_n      = 1'b1;
                        timed_out_n = 1'b1;
                    end else if (step_lat) begin
                        // One enable per request. A request seen while an
                        // enable is already out is dropped, so a held
                        // request alternates.
                        cpu_en_n = step_req & ~cpu_en;
                    end else begin
                        cpu_en_n = 1'b1;
                    end
                end

                default: begin
                    state_n     = S_IDLE;
                    cpu_reset_n = 1'b1;
                    busy_n      = 1'b0;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule
